// File: rtl/tt_io_trace_harness.sv
// Stimulus/capture harness for a tt_um_* DUT: replays queued ui_in words with per-word hold
// counts and logs every uo_out change, with a timestamp, into a capture FIFO.
module tt_io_trace_harness #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8,
  parameter int TS_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              stop,
  input  logic              stim_valid,
  output logic              stim_ready,
  input  logic [DATA_W-1:0] stim_data,
  input  logic [HOLD_W-1:0] stim_hold,
  output logic [DATA_W-1:0] drv_ui_in,
  input  logic [DATA_W-1:0] mon_uo_out,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [DATA_W-1:0] cap_data,
  output logic [TS_W-1:0]   cap_ts,
  output logic              running,
  output logic              underrun,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [TS_W-1:0]   ts;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DATA_W-1:0] last_uo;
  logic              first_run;

  logic [DATA_W+HOLD_W-1:0] stim_mem [DEPTH];
  logic [AW-1:0]            stim_wr_ptr, stim_rd_ptr;
  logic [AW:0]              stim_cnt;
  logic [DATA_W-1:0]        stim_head_data;
  logic [HOLD_W-1:0]        stim_head_hold;

  logic [DATA_W+TS_W-1:0] cap_mem [DEPTH];
  logic [AW-1:0]          cap_wr_ptr, cap_rd_ptr, cap_rd_next;
  logic [AW:0]            cap_cnt;
  logic [DATA_W+TS_W-1:0] cap_wdata;

  logic in_run, stim_push, stim_pop, cap_push, cap_pop, cap_change, cap_room;

  assign in_run     = ena && (state == RUN);
  assign running    = (state == RUN);
  assign stim_ready = ena && (stim_cnt != FULL_CNT);
  assign cap_valid  = ena && (cap_cnt != '0);

  assign stim_push = stim_valid && stim_ready;
  assign stim_pop  = in_run && (hold_cnt == '0) && (stim_cnt != '0);
  assign {stim_head_data, stim_head_hold} = stim_mem[stim_rd_ptr];

  // A full capture FIFO can still accept a push when the bench pops in the same cycle.
  assign cap_pop     = cap_valid && cap_ready;
  assign cap_change  = in_run && (first_run || (mon_uo_out != last_uo));
  assign cap_room    = (cap_cnt != FULL_CNT) || cap_pop;
  assign cap_push    = cap_change && cap_room;
  assign cap_wdata   = {mon_uo_out, ts};
  assign cap_rd_next = cap_rd_ptr + AW'(cap_pop);

  always_ff @(posedge clk) begin
    if (stim_push) stim_mem[stim_wr_ptr] <= {stim_data, stim_hold};
    if (cap_push)  cap_mem[cap_wr_ptr]   <= cap_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ts          <= '0;
      hold_cnt    <= '0;
      last_uo     <= '0;
      first_run   <= 1'b0;
      drv_ui_in   <= '0;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
      stim_wr_ptr <= '0;
      stim_rd_ptr <= '0;
      stim_cnt    <= '0;
      cap_wr_ptr  <= '0;
      cap_rd_ptr  <= '0;
      cap_cnt     <= '0;
      cap_data    <= '0;
      cap_ts      <= '0;
    end else if (ena) begin
      stim_wr_ptr <= stim_wr_ptr + AW'(stim_push);
      stim_rd_ptr <= stim_rd_ptr + AW'(stim_pop);
      stim_cnt    <= stim_cnt + (AW+1)'(stim_push) - (AW+1)'(stim_pop);
      cap_wr_ptr  <= cap_wr_ptr + AW'(cap_push);
      cap_rd_ptr  <= cap_rd_next;
      cap_cnt     <= cap_cnt + (AW+1)'(cap_push) - (AW+1)'(cap_pop);

      // Head register: bypass the write when the new entry lands in an otherwise empty FIFO.
      if (cap_push && (cap_wr_ptr == cap_rd_next))
        {cap_data, cap_ts} <= cap_wdata;
      else
        {cap_data, cap_ts} <= cap_mem[cap_rd_next];

      if (state == IDLE) begin
        if (start && !stop) begin
          state     <= RUN;
          ts        <= '0;
          hold_cnt  <= '0;
          first_run <= 1'b1;
          underrun  <= 1'b0;
          overflow  <= 1'b0;
        end
      end else begin
        if (stop) state <= IDLE;

        if (hold_cnt == '0) begin
          if (stim_cnt != '0) begin
            drv_ui_in <= stim_head_data;
            hold_cnt  <= stim_head_hold;
          end else begin
            underrun <= 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end

        last_uo   <= mon_uo_out;
        first_run <= 1'b0;
        if (cap_change && !cap_room) overflow <= 1'b1;
        if (ts != '1) ts <= ts + 1'b1;
      end
    end
  end
endmodule
